// File: rtl/gf_mul2.sv
// Bit-serial GF(2^m) multiplier, MSB-first shift-and-add, with run-time field degree m and polynomial p.
// Optional operand/parameter checking (err output) is enabled by defining GF_MUL_CHK_EN.
module gf_mul2 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   m,
    input  logic [W:0]   p,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] mul,
    output logic         busy,
    output logic         done
`ifdef GF_MUL_CHK_EN
    ,
    output logic         err
`endif
);

    // Handshake: start is taken on any edge where busy=0 (including the done cycle);
    // busy stays high for the whole iteration; done pulses for one cycle as mul updates.

    localparam logic [W:0] ONE = (W+1)'(1);

    logic [W-1:0] acc_q, acc_d;
    logic [W-1:0] a_q, a_d;
    logic [W-1:0] b_q, b_d;
    logic [W:0]   p_q, p_d;
    logic [2:0]   m_q, m_d;
    logic [2:0]   idx_q, idx_d;
    logic [W-1:0] mul_q, mul_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [2:0]   m_c;
    logic [W:0]   mask_in;
    logic [W:0]   mask_run;
    logic [W:0]   t;

    always_comb begin
        m_c      = (int'(m) > W) ? 3'(W) : m;
        mask_in  = (ONE << m_c) - ONE;
        mask_run = (ONE << m_q) - ONE;
    end

`ifdef GF_MUL_CHK_EN
    logic err_q, err_d;
    logic p_top_set;
    logic over_bits;

    always_comb begin
        p_top_set = |(p & (ONE << m_c));
        over_bits = |({1'b0, a} & ~mask_in) | |({1'b0, b} & ~mask_in);
    end
`endif

    always_comb begin
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        p_d    = p_q;
        m_d    = m_q;
        idx_d  = idx_q;
        mul_d  = mul_q;
        busy_d = busy_q;
        done_d = 1'b0;
        t      = '0;
`ifdef GF_MUL_CHK_EN
        err_d  = err_q;
`endif
        if (!busy_q) begin
            if (start) begin
                // Operands are masked to m bits; the x^m term of p is forced so reduction always applies.
                a_d    = a & mask_in[W-1:0];
                b_d    = b & mask_in[W-1:0];
                p_d    = (p & mask_in) | (ONE << m_c);
                m_d    = m_c;
                idx_d  = (m_c == 3'd0) ? 3'd0 : (m_c - 3'd1);
                acc_d  = '0;
                busy_d = 1'b1;
`ifdef GF_MUL_CHK_EN
                err_d  = (m == 3'd0) || (int'(m) > W) || !p_top_set || over_bits;
`endif
            end
        end else begin
            t = {1'b0, acc_q} << 1;
            if (|(t & (ONE << m_q))) begin
                t = t ^ p_q;
            end
            if (|(b_q & (W'(1) << idx_q))) begin
                t = t ^ {1'b0, a_q};
            end
            t     = t & mask_run;
            acc_d = t[W-1:0];
            if (idx_q == 3'd0) begin
                mul_d  = t[W-1:0];
                busy_d = 1'b0;
                done_d = 1'b1;
            end else begin
                idx_d = idx_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            p_q    <= '0;
            m_q    <= '0;
            idx_q  <= '0;
            mul_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            a_q    <= a_d;
            b_q    <= b_d;
            p_q    <= p_d;
            m_q    <= m_d;
            idx_q  <= idx_d;
            mul_q  <= mul_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

`ifdef GF_MUL_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    assign mul  = mul_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_gf_mul2.sv
// Bench for gf_mul2: directed field vectors, random operands against a polynomial-arithmetic model,
// busy/restart/reset scenarios. Define GF_MUL_CHK_EN to also exercise the err output.
module tb_gf_mul2;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   m;
    logic [W:0]   p;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] mul;
    logic         busy;
    logic         done;
`ifdef GF_MUL_CHK_EN
    logic         err;
`endif

    int checks   = 0;
    int failures = 0;

    gf_mul2 #(.W(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .m     (m),
        .p     (p),
        .a     (a),
        .b     (b),
        .mul   (mul),
        .busy  (busy),
        .done  (done)
`ifdef GF_MUL_CHK_EN
        ,
        .err   (err)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: carry-less product, then polynomial long division by p
    function automatic int eff_m(input int mi);
        return (mi > W) ? W : mi;
    endfunction

    function automatic logic [W-1:0] gf_ref(input int mi, input int pi, input int ai, input int bi);
        int mm, mask, am, bm, poly, prod;
        mm = eff_m(mi);
        if (mm == 0) return '0;
        mask = (1 << mm) - 1;
        am   = ai & mask;
        bm   = bi & mask;
        poly = (pi & mask) | (1 << mm);
        prod = 0;
        for (int i = 0; i < mm; i++)
            if (((bm >> i) & 1) == 1) prod = prod ^ (am << i);
        for (int k = 2 * mm - 2; k >= mm; k--)
            if (((prod >> k) & 1) == 1) prod = prod ^ (poly << (k - mm));
        return W'(prod & mask);
    endfunction

    function automatic int ref_lat(input int mi);
        return (eff_m(mi) == 0) ? 1 : eff_m(mi);
    endfunction

    function automatic logic ref_err(input int mi, input int pi, input int ai, input int bi);
        int mm;
        mm = eff_m(mi);
        if (mi == 0 || mi > W) return 1'b1;
        if (((pi >> mm) & 1) == 0) return 1'b1;
        if ((ai >> mm) != 0 || (bi >> mm) != 0) return 1'b1;
        return 1'b0;
    endfunction

    // driver: one start pulse, then wait for done (bounded); all sampling on negedge
    task automatic do_op(input logic [2:0] mi, input logic [W:0] pi, input logic [W-1:0] ai,
                         input logic [W-1:0] bi, output logic [W-1:0] res, output int lat,
                         output logic busy_after, output logic seen);
        @(negedge clk);
        m = mi; p = pi; a = ai; b = bi; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom);
        busy_after = busy;
        lat = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        seen = done;
        res  = mul;
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; m = '0; p = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (mul !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_state mul=%h busy=%b done=%b required 0/0/0", mul, busy, done);
        end
`ifdef GF_MUL_CHK_EN
        checks++;
        if (err !== 1'b0) begin
            failures++;
            $display("FAIL reset_err err=%b required 0", err);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [W-1:0] res;
        int lat;
        logic ba, seen;
        logic [2:0]   tm [8] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
        logic [W:0]   tp [8] = '{5'b01011, 5'b01011, 5'b01011, 5'b01011, 5'b11001, 5'b11001, 5'b11001, 5'b11001};
        logic [W-1:0] ta [8] = '{4'h5, 4'h6, 4'h4, 4'h4, 4'h8, 4'hB, 4'h3, 4'hC};
        logic [W-1:0] tb [8] = '{4'h7, 4'h3, 4'h2, 4'h5, 4'h9, 4'hF, 4'h4, 4'h5};
        logic [W-1:0] te [8] = '{4'h6, 4'h1, 4'h3, 4'h2, 4'h7, 4'hD, 4'hC, 4'h0};
        int           tl [8] = '{3, 3, 3, 3, 4, 4, 4, 4};
        te[7] = gf_ref(4, 'h19, 'hC, 'h5);
        for (int i = 0; i < 8; i++) begin
            do_op(tm[i], tp[i], ta[i], tb[i], res, lat, ba, seen);
            checks++;
            if (!seen || res !== te[i]) begin
                failures++;
                $display("FAIL directed_%0d mul=%h done_seen=%b required %h", i, res, seen, te[i]);
            end
            checks++;
            if (lat !== tl[i] || ba !== 1'b1) begin
                failures++;
                $display("FAIL directed_lat_%0d latency=%0d busy=%b required %0d/1", i, lat, ba, tl[i]);
            end
        end
        // identity and zero in the x^3+x^2+1 field
        do_op(3'd3, 5'b01101, 4'h0, 4'h0, res, lat, ba, seen);
        checks++;
        if (!seen || res !== 4'h0) begin
            failures++;
            $display("FAIL zero_times_zero mul=%h required 0", res);
        end
        for (int x = 0; x < 8; x++) begin
            do_op(3'd3, 5'b01101, 4'h1, W'(x), res, lat, ba, seen);
            checks++;
            if (!seen || res !== W'(x)) begin
                failures++;
                $display("FAIL identity_%0d mul=%h required %h", x, res, W'(x));
            end
        end
        // m=0: one-cycle latency, result 0
        do_op(3'd0, 5'b11111, 4'hF, 4'hF, res, lat, ba, seen);
        checks++;
        if (!seen || res !== 4'h0 || lat !== 1) begin
            failures++;
            $display("FAIL m_zero mul=%h latency=%0d required 0/1", res, lat);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] res;
        int lat;
        logic ba, seen;
        logic [2:0]   mi;
        logic [W:0]   pi;
        logic [W-1:0] ai, bi;
        for (int n = 0; n < 60; n++) begin
            mi = 3'($urandom_range(0, 7));
            pi = (W+1)'($urandom);
            ai = W'($urandom);
            bi = W'($urandom);
            do_op(mi, pi, ai, bi, res, lat, ba, seen);
            checks++;
            if (!seen || res !== gf_ref(mi, pi, ai, bi) || lat !== ref_lat(mi)) begin
                failures++;
                $display("FAIL random_%0d m=%0d p=%h a=%h b=%h mul=%h lat=%0d required %h lat=%0d",
                         n, mi, pi, ai, bi, res, lat, gf_ref(mi, pi, ai, bi), ref_lat(mi));
            end
`ifdef GF_MUL_CHK_EN
            checks++;
            if (err !== ref_err(mi, pi, ai, bi)) begin
                failures++;
                $display("FAIL random_err_%0d err=%b required %b", n, err, ref_err(mi, pi, ai, bi));
            end
`endif
        end
    endtask

    task automatic test_start_while_busy;
        int lat;
        @(negedge clk);
        m = 3'd4; p = 5'b10011; a = 4'h9; b = 4'hE; start = 1'b1;
        @(negedge clk);
        m = 3'd2; p = 5'b00111; a = 4'h3; b = 4'h1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 2;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (!done || mul !== gf_ref(4, 'h13, 'h9, 'hE) || lat !== 4) begin
            failures++;
            $display("FAIL start_while_busy mul=%h lat=%0d required %h lat=4", mul, lat, gf_ref(4, 'h13, 'h9, 'hE));
        end
        repeat (3) @(negedge clk);
        checks++;
        if (mul !== gf_ref(4, 'h13, 'h9, 'hE) || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL mul_hold mul=%h busy=%b done=%b required %h/0/0", mul, busy, done, gf_ref(4, 'h13, 'h9, 'hE));
        end
    endtask

    task automatic test_back_to_back;
        int lat;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] got;
        exp_q.push_back(gf_ref(3, 'hB, 'h3, 'h6));
        exp_q.push_back(gf_ref(4, 'h19, 'hD, 'hA));
        @(negedge clk);
        m = 3'd3; p = 5'b01011; a = 4'h3; b = 4'h6; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        got = mul;
        // second request presented in the done cycle
        m = 3'd4; p = 5'b11001; a = 4'hD; b = 4'hA; start = 1'b1;
        checks++;
        if (!done || got !== exp_q.pop_front()) begin
            failures++;
            $display("FAIL back_to_back_first mul=%h done=%b", got, done);
        end
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL back_to_back_accept busy=%b done=%b required 1/0", busy, done);
        end
        lat = 0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        checks++;
        if (!done || mul !== exp_q[0] || lat !== 4) begin
            failures++;
            $display("FAIL back_to_back_second mul=%h lat=%0d required %h lat=4", mul, lat, exp_q[0]);
        end
    endtask

    task automatic test_reset_mid_op;
        logic [W-1:0] res;
        int lat, seen_done;
        logic ba, seen;
        @(negedge clk);
        m = 3'd4; p = 5'b11001; a = 4'h7; b = 4'hB; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #2;
        checks++;
        if (mul !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_op mul=%h busy=%b done=%b required 0/0/0", mul, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen_done++;
        end
        checks++;
        if (seen_done != 0 || mul !== '0) begin
            failures++;
            $display("FAIL reset_no_done done_count=%0d mul=%h required 0/0", seen_done, mul);
        end
        do_op(3'd4, 5'b11001, 4'h7, 4'hB, res, lat, ba, seen);
        checks++;
        if (!seen || res !== gf_ref(4, 'h19, 'h7, 'hB) || lat !== 4) begin
            failures++;
            $display("FAIL after_reset mul=%h lat=%0d required %h lat=4", res, lat, gf_ref(4, 'h19, 'h7, 'hB));
        end
    endtask

`ifdef GF_MUL_CHK_EN
    task automatic test_err;
        logic [W-1:0] res;
        int lat;
        logic ba, seen;
        do_op(3'd3, 5'b01011, 4'h8, 4'h5, res, lat, ba, seen);
        checks++;
        if (err !== 1'b1 || res !== 4'h0) begin
            failures++;
            $display("FAIL err_wide_a err=%b mul=%h required 1/0", err, res);
        end
        do_op(3'd5, 5'b10011, 4'h3, 4'h5, res, lat, ba, seen);
        checks++;
        if (err !== 1'b1 || res !== gf_ref(5, 'h13, 'h3, 'h5)) begin
            failures++;
            $display("FAIL err_m_big err=%b mul=%h required 1/%h", err, res, gf_ref(5, 'h13, 'h3, 'h5));
        end
        do_op(3'd3, 5'b00011, 4'h3, 4'h5, res, lat, ba, seen);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL err_p_top err=%b required 1", err);
        end
        do_op(3'd3, 5'b01011, 4'h5, 4'h7, res, lat, ba, seen);
        checks++;
        if (err !== 1'b0 || res !== 4'h6) begin
            failures++;
            $display("FAIL err_valid err=%b mul=%h required 0/6", err, res);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_while_busy;
        test_back_to_back;
        test_reset_mid_op;
`ifdef GF_MUL_CHK_EN
        test_err;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
